usb_tx_sched: RTL and testbench

USB_TX_SCHED -- requirements
Module: usb_tx_sched

---
 rtl/usb_tx_sched_if.sv | 31 +++
 rtl/usb_tx_sched.sv | 127 ++++++++++++
 tb/tb_usb_tx_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_sched_if.sv
// Requester, packet and driver-stage signals of usb_tx_sched.
// master drives the requests and out_done; slave is the scheduler.
interface usb_tx_sched_if;
  logic         tok_req;
  logic [3:0]   tok_pid;
  logic [6:0]   tok_addr;
  logic [3:0]   tok_endp;
  logic         dat_req;
  logic [3:0]   dat_pid;
  logic [63:0]  dat_payload;
  logic         tok_gnt;
  logic         dat_gnt;
  logic [99:0]  pkt_in;
  logic [31:0]  pkt_len;
  logic         pkt_ready;
  logic         out_done;
  logic         busy;
  logic         err_timeout;

  modport master (
    output tok_req, tok_pid, tok_addr, tok_endp,
    output dat_req, dat_pid, dat_payload, out_done,
    input  tok_gnt, dat_gnt, pkt_in, pkt_len, pkt_ready, busy, err_timeout
  );

  modport slave (
    input  tok_req, tok_pid, tok_addr, tok_endp,
    input  dat_req, dat_pid, dat_payload, out_done,
    output tok_gnt, dat_gnt, pkt_in, pkt_len, pkt_ready, busy, err_timeout
  );
endinterface

// File: rtl/usb_tx_sched.sv
// USB TX scheduler: round-robin token/data arbitration, packet assembly and inter-packet gap.
// Optional SEND watchdog enabled by defining USB_TX_TIMEOUT_EN.
module usb_tx_sched #(
  parameter int unsigned IPG_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clock,
  input  logic          reset_n,
  usb_tx_sched_if.slave bus
);

  // One counter serves both the GAP length and the SEND watchdog.
  localparam int unsigned CntMax = (IPG_CYCLES > TIMEOUT_CYCLES) ? IPG_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);
  localparam logic [CntW-1:0] IpgLast = CntW'((IPG_CYCLES == 0) ? 0 : IPG_CYCLES - 1);
`ifdef USB_TX_TIMEOUT_EN
  localparam logic [CntW-1:0] TmoLast = CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic            pref_tok;
  logic            tok_gnt_q;
  logic            dat_gnt_q;
  logic            pkt_ready_q;
  logic            busy_q;
  logic [99:0]     pkt_in_q;
  logic [31:0]     pkt_len_q;
  logic            err_q;
  logic            pick_tok;

  assign pick_tok = bus.tok_req && (!bus.dat_req || pref_tok);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pref_tok    <= 1'b1;
      tok_gnt_q   <= 1'b0;
      dat_gnt_q   <= 1'b0;
      pkt_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      pkt_in_q    <= '0;
      pkt_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      tok_gnt_q   <= 1'b0;
      dat_gnt_q   <= 1'b0;
      pkt_ready_q <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tok_req || bus.dat_req) begin
            state       <= LOAD;
            busy_q      <= 1'b1;
            pkt_ready_q <= 1'b1;
            if (pick_tok) begin
              tok_gnt_q <= 1'b1;
              pref_tok  <= 1'b0;
              pkt_in_q  <= {81'b0, bus.tok_endp, bus.tok_addr, ~bus.tok_pid, bus.tok_pid};
              pkt_len_q <= 32'd19;
            end else begin
              dat_gnt_q <= 1'b1;
              pref_tok  <= 1'b1;
              pkt_in_q  <= {28'b0, bus.dat_payload, ~bus.dat_pid, bus.dat_pid};
              pkt_len_q <= 32'd72;
            end
          end
        end
        LOAD: begin
          state <= SEND;
          cnt   <= '0;
        end
        SEND: begin
          // out_done wins over a watchdog expiring on the same edge.
          if (bus.out_done
`ifdef USB_TX_TIMEOUT_EN
              || (cnt == TmoLast)
`endif
             ) begin
`ifdef USB_TX_TIMEOUT_EN
            err_q <= !bus.out_done;
`endif
            cnt <= '0;
            if (IPG_CYCLES == 0) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
`ifdef USB_TX_TIMEOUT_EN
            cnt <= cnt + CntW'(1);
`endif
          end
        end
        GAP: begin
          if (cnt == IpgLast) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tok_gnt   = tok_gnt_q;
  assign bus.dat_gnt   = dat_gnt_q;
  assign bus.pkt_ready = pkt_ready_q;
  assign bus.pkt_in    = pkt_in_q;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.busy      = busy_q;
`ifdef USB_TX_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_sched.sv
// Scoreboard bench for usb_tx_sched: randomized requesters, spec-level packet/arbitration model,
// decoupled negedge monitor checking packets, grant pulses, spacing, stability and reset.
module tb_usb_tx_sched;
  localparam int IPG    = 3;
  localparam int TMO    = 16;
  localparam int ROUNDS = 24;
`ifdef USB_TX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    bit          is_tok;
    logic [99:0] pkt;
    logic [31:0] len;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  int          exp_ready_edge = 0;
  int          exp_tmo = 0;
  bit          tmo_armed = 1'b0;
  bit          pref_tok = 1'b1;
  logic [99:0] held_pkt = '0;
  logic [31:0] held_len = '0;

  usb_tx_sched_if bus ();

  usb_tx_sched #(
    .IPG_CYCLES     (IPG),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic void check(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic exp_t tok_pkt(logic [3:0] pid, logic [6:0] addr, logic [3:0] endp);
    exp_t e;
    e.is_tok    = 1'b1;
    e.pkt       = '0;
    e.pkt[18:0] = {endp, addr, ~pid, pid};
    e.len       = 32'd19;
    return e;
  endfunction

  function automatic exp_t dat_pkt(logic [3:0] pid, logic [63:0] payload);
    exp_t e;
    e.is_tok    = 1'b0;
    e.pkt       = '0;
    e.pkt[71:0] = {payload, ~pid, pid};
    e.len       = 32'd72;
    return e;
  endfunction

  // Round-robin model: the requester not granted last goes first when both wait.
  function automatic void push_round(bit t, bit d, exp_t et, exp_t ed);
    if (t && d) begin
      if (pref_tok) begin sb.push_back(et); sb.push_back(ed); end
      else begin sb.push_back(ed); sb.push_back(et); end
    end else if (t) begin
      sb.push_back(et);
      pref_tok = 1'b0;
    end else if (d) begin
      sb.push_back(ed);
      pref_tok = 1'b1;
    end
  endfunction

  task automatic abort_run(string what);
    checks++;
    failures++;
    $display("FAIL %s: no DUT response within bound", what);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic wait_gnt(output bit was_tok);
    int n = 0;
    was_tok = 1'b0;
    @(negedge clock);
    while (!(bus.tok_gnt || bus.dat_gnt)) begin
      n++;
      if (n > 200) begin abort_run("wait_gnt"); return; end
      @(negedge clock);
    end
    was_tok = bus.tok_gnt;
  endtask

  task automatic issue_done();
    bus.out_done   = 1'b1;
    exp_ready_edge = edge_cnt + 1 + IPG + 1;
    @(negedge clock);
    // a second high cycle is sampled in GAP and must not disturb it
    if ($urandom_range(1, 0) == 1) @(negedge clock);
    bus.out_done = 1'b0;
  endtask

  task automatic serve(input bit other_pending, input bit skip_done);
    bit was_tok;
    int n;
    wait_gnt(was_tok);
    if (skip_done) begin
      exp_tmo   = edge_cnt + 1 + TMO;
      tmo_armed = 1'b1;
    end
    if (was_tok) bus.tok_req = 1'b0; else bus.dat_req = 1'b0;
    if ($urandom_range(2, 0) == 0) bus.out_done = 1'b1;
    @(negedge clock);
    bus.out_done = 1'b0;
    if (!other_pending && $urandom_range(1, 0) == 1) begin
      if ($urandom_range(1, 0) == 1) bus.tok_req = 1'b1; else bus.dat_req = 1'b1;
      repeat (2) @(negedge clock);
      bus.tok_req = 1'b0;
      bus.dat_req = 1'b0;
    end
    repeat ($urandom_range(3, 0)) @(negedge clock);
    if (skip_done) begin
      n = 0;
      while (!bus.err_timeout) begin
        n++;
        if (n > TMO + 20) begin abort_run("wait_err_timeout"); return; end
        @(negedge clock);
      end
      exp_ready_edge = edge_cnt + IPG + 1;
      @(negedge clock);
      tmo_armed = 1'b0;
    end else begin
      issue_done();
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      check("reset_ctrl", 160'({bus.pkt_ready, bus.tok_gnt, bus.dat_gnt, bus.busy, bus.err_timeout}), 160'(0));
      check("reset_pkt", 160'({bus.pkt_len, bus.pkt_in}), 160'(0));
      held_pkt = '0;
      held_len = '0;
    end else begin
      check("err_timeout", 160'(bus.err_timeout), 160'(tmo_armed && (edge_cnt == exp_tmo)));
      if (bus.pkt_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pkt_ready: got pkt_ready=1 expected no packet");
        end else begin
          mon_e = sb.pop_front();
          check("grant", 160'({bus.tok_gnt, bus.dat_gnt}), 160'({mon_e.is_tok, ~mon_e.is_tok}));
          check("pkt_in", 160'(bus.pkt_in), 160'(mon_e.pkt));
          check("pkt_len", 160'(bus.pkt_len), 160'(mon_e.len));
          check("busy_in_load", 160'(bus.busy), 160'(1));
          check("ready_edge", 160'(edge_cnt), 160'(exp_ready_edge));
        end
        held_pkt = bus.pkt_in;
        held_len = bus.pkt_len;
      end else begin
        check("gnt_without_ready", 160'({bus.tok_gnt, bus.dat_gnt}), 160'(0));
        check("pkt_stable", 160'({bus.pkt_len, bus.pkt_in}), 160'({held_len, held_pkt}));
      end
    end
  end

  initial begin
    #200000;
    abort_run("watchdog");
  end

  initial begin
    bit   t, d;
    int   m;
    exp_t et, ed, eb;
    bus.tok_req = 1'b0; bus.tok_pid = '0; bus.tok_addr = '0; bus.tok_endp = '0;
    bus.dat_req = 1'b0; bus.dat_pid = '0; bus.dat_payload = '0; bus.out_done = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("idle_busy", 160'(bus.busy), 160'(0));

    for (int r = 0; r < ROUNDS; r++) begin
      if (r == 0) begin
        t = 1'b1; d = 1'b0;
        bus.tok_pid = 4'b0001; bus.tok_addr = 7'd5; bus.tok_endp = 4'd4;
        et.is_tok = 1'b1; et.pkt = {81'b0, 19'b0100_0000101_11100001}; et.len = 32'd19;
      end else if (r == 1) begin
        t = 1'b0; d = 1'b1;
        bus.dat_pid = 4'b0011; bus.dat_payload = 64'hDEADBEEF_01234567;
        ed.is_tok = 1'b0; ed.pkt = {28'b0, 64'hDEADBEEF_01234567, 8'b1100_0011}; ed.len = 32'd72;
      end else begin
        if (r == 2 || r == 3) m = 3; else m = $urandom_range(3, 1);
        t = m[1]; d = m[0];
        bus.tok_pid = 4'($urandom); bus.tok_addr = 7'($urandom); bus.tok_endp = 4'($urandom);
        bus.dat_pid = 4'($urandom); bus.dat_payload = {$urandom, $urandom};
        et = tok_pkt(bus.tok_pid, bus.tok_addr, bus.tok_endp);
        ed = dat_pkt(bus.dat_pid, bus.dat_payload);
      end
      push_round(t, d, et, ed);
      if (r == 0) exp_ready_edge = edge_cnt + 1;
      bus.tok_req = t;
      bus.dat_req = d;
      if (t && d) serve(1'b1, 1'b0);
      serve(1'b0, TMO_EN && (r == 5));
    end

    repeat (IPG + 3) @(negedge clock);
    check("busy_after_gap", 160'(bus.busy), 160'(0));

    // Reset during SEND: packet A abandoned, B (held through reset) and D granted token-first.
    bus.tok_pid = 4'($urandom); bus.tok_addr = 7'($urandom); bus.tok_endp = 4'($urandom);
    et = tok_pkt(bus.tok_pid, bus.tok_addr, bus.tok_endp);
    push_round(1'b1, 1'b0, et, ed);
    exp_ready_edge = edge_cnt + 1;
    bus.tok_req = 1'b1;
    wait_gnt(t);
    bus.tok_req = 1'b0;
    repeat (2) @(negedge clock);
    bus.tok_pid = 4'($urandom); bus.tok_addr = 7'($urandom); bus.tok_endp = 4'($urandom);
    bus.dat_pid = 4'($urandom); bus.dat_payload = {$urandom, $urandom};
    eb = tok_pkt(bus.tok_pid, bus.tok_addr, bus.tok_endp);
    ed = dat_pkt(bus.dat_pid, bus.dat_payload);
    bus.tok_req = 1'b1;
    bus.dat_req = 1'b1;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_ctrl", 160'({bus.pkt_ready, bus.tok_gnt, bus.dat_gnt, bus.busy, bus.err_timeout}), 160'(0));
    check("async_reset_pkt", 160'({bus.pkt_len, bus.pkt_in}), 160'(0));
    pref_tok = 1'b1;
    push_round(1'b1, 1'b1, eb, ed);
    @(negedge clock);
    @(negedge clock);
    exp_ready_edge = edge_cnt + 1;
    #1 reset_n = 1'b1;
    serve(1'b1, 1'b0);
    serve(1'b0, 1'b0);

    repeat (IPG + 3) @(negedge clock);
    check("busy_final", 160'(bus.busy), 160'(0));
    check("scoreboard_empty", 160'(sb.size()), 160'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
